inert_spi_serf: RTL and testbench

Synthesizable SPI serf modelling the inertial sensor at the far end of the inertial interface's SPI link. It decodes 16-bit read/write command frames from the SPI monarch, serves a small register file (identity, control, yaw-rate output), and raises `INT` when a new yaw-rate sample is latched. It sits in place of the physical sensor for full-chip simulation and FPGA loop-back, clocked from the system clock with all SPI inputs oversampled.

---
 rtl/inert_spi_pkg.sv | 32 +++
 rtl/spi_serf_shift.sv | 140 ++++++++++++++
 rtl/inert_spi_serf.sv | 150 +++++++++++++++
 tb/tb_inert_spi_serf.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/inert_spi_pkg.sv
// ============================================================================
// Module      : inert_spi_pkg
// Description : Shared types, frame layout and register map for the inertial
//               sensor SPI serf model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inert_spi_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } serf_state_t;

    // Frame layout: R/W flag, register address, write data (MSB first)
    localparam int c_frm_bits     = 16;
    localparam int c_frm_rw_bit   = 15;
    localparam int c_frm_addr_msb = 14;
    localparam int c_frm_addr_lsb = 8;
    localparam int c_data_bits    = 8;

    localparam logic [6:0] c_addr_int1_ctrl = 7'h0D;
    localparam logic [6:0] c_addr_who_am_i  = 7'h0F;
    localparam logic [6:0] c_addr_ctrl1_xl  = 7'h10;
    localparam logic [6:0] c_addr_ctrl2_g   = 7'h11;
    localparam logic [6:0] c_addr_outz_l_g  = 7'h26;
    localparam logic [6:0] c_addr_outz_h_g  = 7'h27;

endpackage

`default_nettype wire

// File: rtl/spi_serf_shift.sv
// ============================================================================
// Module      : spi_serf_shift
// Description : SPI pin oversampling, edge detection, frame FSM and the
//               receive/transmit shifters of the serf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_serf_shift
    import inert_spi_pkg::*;
#(
    parameter int ADDR_W = 7
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic [7:0]        tx_data,
    output logic              miso,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wdata,
    output logic              is_rd,
    output logic              ld_tx,
    output logic              frm_done
);

    logic [1:0]  r_ss_sync;
    logic [1:0]  r_sclk_sync;
    logic [1:0]  r_mosi_sync;
    logic        r_ss_d;
    logic        r_sclk_d;
    serf_state_t r_state;
    serf_state_t w_next_state;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_rx;
    logic [7:0]  r_tx;

    logic        w_ss;
    logic        w_sclk;
    logic        w_mosi;
    logic        w_ss_fall;
    logic        w_ss_rise;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_shifting;
    logic        w_start;
    logic        w_rise;
    logic        w_fall;
    logic [15:0] w_rx_next;

    assign w_ss        = r_ss_sync[1];
    assign w_sclk      = r_sclk_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_ss_fall   = ~w_ss & r_ss_d;
    assign w_ss_rise   = w_ss & ~r_ss_d;
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_rx_next   = {r_rx[14:0], w_mosi};

    // Idle levels: SS_n deasserted, SCLK high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_sync   <= 2'b11;
            r_sclk_sync <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_ss_d      <= 1'b1;
            r_sclk_d    <= 1'b1;
        end else begin
            r_ss_sync   <= {r_ss_sync[0], ss_n};
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_ss_d      <= w_ss;
            r_sclk_d    <= w_sclk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_ss_fall) w_next_state = SHIFT;
            SHIFT:   if (w_ss_rise) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // During the load pulse the byte just completed is still in flight, so
    // the address is taken from the next-shift value rather than r_rx.
    always_comb begin
        w_shifting = (r_state == SHIFT);
        w_start    = (r_state == IDLE) & w_ss_fall;
        w_rise     = w_shifting & w_sclk_rise;
        w_fall     = w_shifting & w_sclk_fall;
        ld_tx      = w_rise & (r_bit_cnt == 5'd7);
        frm_done   = w_shifting & w_ss_rise & (r_bit_cnt == 5'd16);
        busy       = w_shifting;
        miso       = w_shifting & r_tx[7];
        wdata      = r_rx[c_data_bits-1:0];
        if (ld_tx) begin
            addr  = w_rx_next[ADDR_W-1:0];
            is_rd = w_rx_next[ADDR_W];
        end else begin
            addr  = r_rx[c_frm_addr_lsb +: ADDR_W];
            is_rd = r_rx[c_frm_rw_bit];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 5'd0;
            r_rx      <= 16'h0000;
            r_tx      <= 8'h00;
        end else if (w_start) begin
            r_bit_cnt <= 5'd0;
            r_rx      <= 16'h0000;
            r_tx      <= 8'h00;
        end else if (w_rise && (r_bit_cnt != 5'd16)) begin
            r_rx      <= w_rx_next;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (ld_tx) begin
                r_tx <= is_rd ? tx_data : 8'h00;
            end
        end else if (w_fall && (r_bit_cnt >= 5'd9)) begin
            r_tx <= {r_tx[6:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/inert_spi_serf.sv
// ============================================================================
// Module      : inert_spi_serf
// Description : Inertial sensor SPI serf model: register file, yaw-rate
//               sample capture and data-ready interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inert_spi_serf
    import inert_spi_pkg::*;
#(
    parameter int         ADDR_W       = 7,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h6A
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] yaw_rt,
    input  logic        yaw_vld
);

    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_wdata;
    logic              w_is_rd;
    logic              w_ld_tx;
    logic              w_frm_done;
    logic              w_busy;
    logic [7:0]        w_rd_data;
    logic              w_land;
    logic [15:0]       w_land_data;

    logic [7:0]        r_int1_ctrl;
    logic [7:0]        r_ctrl1_xl;
    logic [7:0]        r_ctrl2_g;
    logic [15:0]       r_outz;
    logic              r_pend_vld;
    logic [15:0]       r_pend_data;
    logic              r_int;
    logic              r_commit;
    logic              r_commit_rd;
    logic [ADDR_W-1:0] r_commit_addr;
    logic [7:0]        r_commit_data;

    spi_serf_shift #(
        .ADDR_W (ADDR_W)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (SS_n),
        .sclk     (SCLK),
        .mosi     (MOSI),
        .tx_data  (w_rd_data),
        .miso     (MISO),
        .busy     (w_busy),
        .addr     (w_addr),
        .wdata    (w_wdata),
        .is_rd    (w_is_rd),
        .ld_tx    (w_ld_tx),
        .frm_done (w_frm_done)
    );

    always_comb begin
        w_rd_data = 8'h00;
        case (w_addr)
            ADDR_W'(c_addr_who_am_i):  w_rd_data = WHO_AM_I_VAL;
            ADDR_W'(c_addr_int1_ctrl): w_rd_data = r_int1_ctrl;
            ADDR_W'(c_addr_ctrl1_xl):  w_rd_data = r_ctrl1_xl;
            ADDR_W'(c_addr_ctrl2_g):   w_rd_data = r_ctrl2_g;
            ADDR_W'(c_addr_outz_l_g):  w_rd_data = r_outz[7:0];
            ADDR_W'(c_addr_outz_h_g):  w_rd_data = r_outz[15:8];
            default:                   w_rd_data = 8'h00;
        endcase
    end

    // Commit is delayed one cycle so an INT clear lines up with the
    // pending-sample transfer, letting a same-cycle set take priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit      <= 1'b0;
            r_commit_rd   <= 1'b0;
            r_commit_addr <= '0;
            r_commit_data <= 8'h00;
        end else begin
            r_commit      <= w_frm_done;
            r_commit_rd   <= w_is_rd;
            r_commit_addr <= w_addr;
            r_commit_data <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int1_ctrl <= 8'h00;
            r_ctrl1_xl  <= 8'h00;
            r_ctrl2_g   <= 8'h00;
        end else if (r_commit && !r_commit_rd) begin
            case (r_commit_addr)
                ADDR_W'(c_addr_int1_ctrl): r_int1_ctrl <= r_commit_data;
                ADDR_W'(c_addr_ctrl1_xl):  r_ctrl1_xl  <= r_commit_data;
                ADDR_W'(c_addr_ctrl2_g):   r_ctrl2_g   <= r_commit_data;
                default: ;
            endcase
        end
    end

    // A fresh strobe outside a frame beats an older pending sample.
    always_comb begin
        w_land      = !w_busy && (yaw_vld || r_pend_vld);
        w_land_data = yaw_vld ? yaw_rt : r_pend_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outz      <= 16'h0000;
            r_pend_vld  <= 1'b0;
            r_pend_data <= 16'h0000;
        end else begin
            if (w_land) begin
                r_outz <= w_land_data;
            end
            if (yaw_vld && w_busy) begin
                r_pend_vld  <= 1'b1;
                r_pend_data <= yaw_rt;
            end else if (!w_busy) begin
                r_pend_vld  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int <= 1'b0;
        end else if (w_land && r_int1_ctrl[1]) begin
            r_int <= 1'b1;
        end else if (r_commit && r_commit_rd &&
                     (r_commit_addr == ADDR_W'(c_addr_outz_h_g))) begin
            r_int <= 1'b0;
        end
    end

    assign INT = r_int;

endmodule

`default_nettype wire

// File: tb/tb_inert_spi_serf.sv
// ============================================================================
// Module      : tb_inert_spi_serf
// Description : Scoreboard bench for inert_spi_serf driving SPI frames and
//               checking MISO read bytes and INT behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inert_spi_serf;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        SS_n    = 1'b1;
    logic        SCLK    = 1'b1;
    logic        MOSI    = 1'b0;
    logic        yaw_vld = 1'b0;
    logic [15:0] yaw_rt  = 16'h0000;
    logic        MISO;
    logic        INT;

    always #5 clk = ~clk;

    inert_spi_serf #(
        .ADDR_W       (7),
        .WHO_AM_I_VAL (8'h6A)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .INT     (INT),
        .yaw_rt  (yaw_rt),
        .yaw_vld (yaw_vld)
    );

    typedef struct {
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: reassemble what the monarch sees on MISO at each SCLK rise
    logic [15:0] mon_miso = 16'h0000;
    logic [15:0] mon_mosi = 16'h0000;
    int          mon_bits = 0;

    always @(negedge SS_n) mon_bits = 0;

    always @(posedge SCLK) begin
        if (SS_n == 1'b0) begin
            mon_miso = {mon_miso[14:0], MISO};
            mon_mosi = {mon_mosi[14:0], MOSI};
            mon_bits++;
        end
    end

    always @(posedge SS_n) begin : mon_pop
        exp_t e;
        if (mon_bits == 16 && mon_mosi[15]) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_read: got %h expected no frame", mon_miso);
            end else begin
                e = exp_q.pop_front();
                check(e.name, mon_miso, e.val);
            end
        end
    end

    task automatic spi_frame(input logic [15:0] word, input int nclk, input bit do_rst);
        @(negedge clk);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            SCLK = 1'b0;
            MOSI = word[15-i];
            repeat (10) @(negedge clk);
            SCLK = 1'b1;
            repeat (10) @(negedge clk);
        end
        if (do_rst) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            check("miso_in_reset", {15'd0, MISO}, 16'd0);
            check("int_in_reset", {15'd0, INT}, 16'd0);
            SS_n = 1'b1;
            repeat (4) @(negedge clk);
            rst_n = 1'b1;
        end else begin
            SS_n = 1'b1;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] exp_byte, input string name);
        exp_t e;
        e.val  = {8'h00, exp_byte};
        e.name = name;
        exp_q.push_back(e);
        spi_frame({1'b1, a, 8'h00}, 16, 1'b0);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        spi_frame({1'b0, a, d}, 16, 1'b0);
    endtask

    task automatic yaw(input logic [15:0] v);
        @(negedge clk);
        yaw_rt  = v;
        yaw_vld = 1'b1;
        @(negedge clk);
        yaw_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_miso", {15'd0, MISO}, 16'd0);
        check("reset_int", {15'd0, INT}, 16'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        rd(7'h0F, 8'h6A, "rd_who_am_i");
        check("miso_deselected", {15'd0, MISO}, 16'd0);
        wr(7'h0F, 8'hFF);
        rd(7'h0F, 8'h6A, "rd_who_am_i_ro");
        rd(7'h20, 8'h00, "rd_unmapped");

        wr(7'h0D, 8'h02);
        rd(7'h0D, 8'h02, "rd_int1_ctrl");
        check("int_no_sample", {15'd0, INT}, 16'd0);

        yaw(16'hBEEF);
        check("int_set_idle", {15'd0, INT}, 16'd1);
        rd(7'h26, 8'hEF, "rd_outz_l");
        check("int_after_26", {15'd0, INT}, 16'd1);
        rd(7'h27, 8'hBE, "rd_outz_h");
        check("int_clr_27", {15'd0, INT}, 16'd0);

        yaw(16'hBEEF);
        check("int_set_again", {15'd0, INT}, 16'd1);
        fork
            rd(7'h27, 8'hBE, "rd_outz_h_mid_sample");
            begin
                repeat (100) @(negedge clk);
                yaw(16'h1234);
            end
        join
        check("int_set_wins", {15'd0, INT}, 16'd1);
        rd(7'h26, 8'h34, "rd_outz_l_pending");
        rd(7'h27, 8'h12, "rd_outz_h_pending");
        check("int_clr_pending", {15'd0, INT}, 16'd0);

        spi_frame(16'h1055, 12, 1'b0);
        rd(7'h10, 8'h00, "rd_ctrl1_after_abort");
        wr(7'h10, 8'h55);
        rd(7'h10, 8'h55, "rd_ctrl1_full");

        wr(7'h11, 8'hAA);
        rd(7'h11, 8'hAA, "rd_ctrl2");
        yaw(16'h5678);
        check("int_before_reset", {15'd0, INT}, 16'd1);
        spi_frame(16'h11CC, 9, 1'b1);
        check("int_after_reset", {15'd0, INT}, 16'd0);
        rd(7'h11, 8'h00, "rd_ctrl2_reset");
        rd(7'h10, 8'h00, "rd_ctrl1_reset");
        rd(7'h0D, 8'h00, "rd_int1_reset");
        rd(7'h27, 8'h00, "rd_outz_h_reset");
        rd(7'h0F, 8'h6A, "rd_who_am_i_post_reset");

        check("exp_queue_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
